spi_data_transmitter: RTL and testbench

//  SPI master MOSI serializer; companion to the MISO data receiver in the SPI base block.

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_data_transmitter.sv | 129 ++++++++++++
 tb/tb_spi_data_transmitter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions used by the MOSI transmitter and the MISO receiver.
package spi_pkg;

  // Serializer FSM: waiting for a word, or driving a word onto the line.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_t;

  // Default bits per transfer word.
  localparam int SPI_DATA_WIDTH = 8;

  // Line level driven while no word is being shifted.
  localparam logic SPI_IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/spi_data_transmitter.sv
// SPI mode-0 MOSI serializer with a 1-deep holding register.
// A word is accepted over valid/ready into the holding register, moved into
// the shift register when the line is free, and shifted out MSB-first on
// each SCL falling-edge strobe. A held word reloads on the last falling edge
// of the current word, so back-to-back words go out without a gap.
module spi_data_transmitter
  import spi_pkg::*;
#(
  parameter int   DATA_WIDTH = SPI_DATA_WIDTH,
  parameter logic IDLE_LEVEL = SPI_IDLE_LEVEL
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  en_i,
  input  logic                  scl_neg_edge_detected_i,
  input  logic                  data_valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  data_ready_o,
  output logic                  mosi_o,
  output logic                  busy_o,
  output logic                  byte_done_o
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  spi_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] shifted;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  mosi_q, mosi_d;
  logic                  done_q, done_d;

  // Ready and busy come straight from registered state, so there is no
  // combinational path from any input to the handshake.
  assign data_ready_o = ~hold_full_q;
  assign busy_o       = (state_q == SHIFT);
  assign mosi_o       = mosi_q;
  assign byte_done_o  = done_q;

  assign shifted = shift_q << 1;

  // State register: every piece of block state updates together here.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= LAST_BIT;
      mosi_q      <= IDLE_LEVEL;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      mosi_q      <= mosi_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic: FSM transfer/shift first, then the handshake accept.
  // The two cannot collide on hold_full: the FSM only consumes a full
  // holding register and the accept only fills an empty one.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    mosi_d      = mosi_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          bit_cnt_d   = LAST_BIT;
          mosi_d      = hold_q[DATA_WIDTH-1];
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (scl_neg_edge_detected_i) begin
          if (bit_cnt_q != '0) begin
            bit_cnt_d = bit_cnt_q - CNT_W'(1);
            shift_d   = shifted;
            mosi_d    = shifted[DATA_WIDTH-1];
          end else begin
            done_d = 1'b1;
            if (hold_full_q) begin
              shift_d     = hold_q;
              hold_full_d = 1'b0;
              bit_cnt_d   = LAST_BIT;
              mosi_d      = hold_q[DATA_WIDTH-1];
            end else begin
              state_d = IDLE;
              mosi_d  = IDLE_LEVEL;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (data_valid_i && !hold_full_q) begin
      hold_d      = data_i;
      hold_full_d = 1'b1;
    end

    // Disabling flushes everything, including any held or in-flight word,
    // without reporting it as done.
    if (!en_i) begin
      state_d     = IDLE;
      hold_d      = '0;
      hold_full_d = 1'b0;
      shift_d     = '0;
      bit_cnt_d   = LAST_BIT;
      mosi_d      = IDLE_LEVEL;
      done_d      = 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_data_transmitter.sv
// Directed bench for spi_data_transmitter: a queue holds the bits each
// accepted word must put on mosi_o, and they are popped as the line moves.
module tb_spi_data_transmitter;
  import spi_pkg::*;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       en_i = 1'b1;
  logic       scl_neg_edge_detected_i = 1'b0;
  logic       data_valid_i = 1'b0;
  logic [7:0] data_i = '0;
  logic       data_ready_o;
  logic       mosi_o;
  logic       busy_o;
  logic       byte_done_o;

  int   checks = 0;
  int   failures = 0;
  int   done_count = 0;
  logic exp_bits[$];

  spi_data_transmitter #(
    .DATA_WIDTH (8),
    .IDLE_LEVEL (1'b0)
  ) dut (
    .clk_i                   (clk_i),
    .reset_i                 (reset_i),
    .en_i                    (en_i),
    .scl_neg_edge_detected_i (scl_neg_edge_detected_i),
    .data_valid_i            (data_valid_i),
    .data_i                  (data_i),
    .data_ready_o            (data_ready_o),
    .mosi_o                  (mosi_o),
    .busy_o                  (busy_o),
    .byte_done_o             (byte_done_o)
  );

  // Free-running 100 MHz clock.
  always #5 clk_i = ~clk_i;

  // Count byte_done_o cycles, sampled mid-cycle away from the active edge.
  always @(negedge clk_i) begin
    if (byte_done_o) done_count++;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Offer a word until accepted (bounded); push its bits MSB-first on accept.
  task automatic applyStimulus(input logic [7:0] value);
    bit accepted = 0;
    data_valid_i = 1'b1;
    data_i       = value;
    for (int i = 0; i < 50 && !accepted; i++) begin
      if (data_ready_o) accepted = 1;
      tick();
    end
    data_valid_i = 1'b0;
    if (accepted) begin
      for (int b = 7; b >= 0; b--) exp_bits.push_back(value[b]);
    end else begin
      checks++;
      failures++;
      $error("[TB] FAIL accept_timeout observed=0 expected=1");
    end
  endtask

  // One SCL falling-edge strobe, preceded by a small idle gap.
  task automatic strobe();
    tick();
    scl_neg_edge_detected_i = 1'b1;
    tick();
    scl_neg_edge_detected_i = 1'b0;
  endtask

  task automatic popCheck(input string tag);
    logic exp_bit;
    if (exp_bits.size() == 0) begin
      checks++;
      failures++;
      $error("[TB] FAIL %s observed=%0b expected=queue_entry", tag, mosi_o);
    end else begin
      exp_bit = exp_bits.pop_front();
      checkOutput(tag, 32'(mosi_o), 32'(exp_bit));
    end
  endtask

  // Present the remaining 7 bits of the word currently on the line.
  task automatic shiftRest(input string tag);
    for (int i = 0; i < 7; i++) begin
      strobe();
      popCheck(tag);
      checkOutput({tag, "_busy"}, 32'(busy_o), 32'd1);
    end
  endtask

  initial begin
    int done_ref;

    // 1. Reset values, then an asynchronous mid-cycle reset.
    tick();
    tick();
    reset_i = 1'b0;
    checkOutput("rst_mosi", 32'(mosi_o), 32'd0);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_ready", 32'(data_ready_o), 32'd1);
    checkOutput("rst_done", 32'(byte_done_o), 32'd0);

    applyStimulus(8'hFF);
    tick();
    checkOutput("pre_rst_busy", 32'(busy_o), 32'd1);
    checkOutput("pre_rst_mosi", 32'(mosi_o), 32'd1);
    #3;
    reset_i = 1'b1;
    #1;
    checkOutput("async_rst_mosi", 32'(mosi_o), 32'd0);
    checkOutput("async_rst_busy", 32'(busy_o), 32'd0);
    checkOutput("async_rst_ready", 32'(data_ready_o), 32'd1);
    checkOutput("async_rst_done", 32'(byte_done_o), 32'd0);
    tick();
    reset_i = 1'b0;
    exp_bits.delete();
    done_count = 0;

    // 2. Single byte 0xA5 with two-clock latency to the MSB.
    applyStimulus(8'hA5);
    checkOutput("a5_ready_held", 32'(data_ready_o), 32'd0);
    checkOutput("a5_not_busy_yet", 32'(busy_o), 32'd0);
    tick();
    checkOutput("a5_busy", 32'(busy_o), 32'd1);
    popCheck("a5_msb");
    shiftRest("a5_bit");
    strobe();
    checkOutput("a5_done", 32'(byte_done_o), 32'd1);
    checkOutput("a5_end_busy", 32'(busy_o), 32'd0);
    checkOutput("a5_end_mosi", 32'(mosi_o), 32'd0);
    tick();
    checkOutput("a5_done_pulse", 32'(byte_done_o), 32'd0);
    checkOutput("a5_done_count", 32'(done_count), 32'd1);

    // 3. Back-to-back 0x3C then 0xC3 with no gap.
    done_ref = done_count;
    applyStimulus(8'h3C);
    checkOutput("b2b_ready_full", 32'(data_ready_o), 32'd0);
    tick();
    checkOutput("b2b_ready_free", 32'(data_ready_o), 32'd1);
    popCheck("3c_msb");
    applyStimulus(8'hC3);
    checkOutput("b2b_ready_full2", 32'(data_ready_o), 32'd0);
    shiftRest("3c_bit");
    strobe();
    checkOutput("b2b_done1", 32'(byte_done_o), 32'd1);
    checkOutput("b2b_busy_gapless", 32'(busy_o), 32'd1);
    popCheck("c3_msb");
    shiftRest("c3_bit");
    strobe();
    checkOutput("b2b_end_busy", 32'(busy_o), 32'd0);
    tick();
    checkOutput("b2b_done_count", 32'(done_count - done_ref), 32'd2);

    // 4. Stray strobes in IDLE do nothing.
    done_ref = done_count;
    for (int i = 0; i < 3; i++) begin
      strobe();
      checkOutput("stray_mosi", 32'(mosi_o), 32'd0);
      checkOutput("stray_busy", 32'(busy_o), 32'd0);
    end
    checkOutput("stray_done_count", 32'(done_count - done_ref), 32'd0);

    // 5. Flush mid-word with a byte held, then a clean 0x01.
    done_ref = done_count;
    applyStimulus(8'hFF);
    tick();
    popCheck("ff_msb");
    applyStimulus(8'h81);
    strobe();
    popCheck("ff_bit");
    strobe();
    popCheck("ff_bit");
    en_i = 1'b0;
    tick();
    checkOutput("flush_busy", 32'(busy_o), 32'd0);
    checkOutput("flush_ready", 32'(data_ready_o), 32'd1);
    checkOutput("flush_mosi", 32'(mosi_o), 32'd0);
    exp_bits.delete();
    en_i = 1'b1;
    tick();
    checkOutput("flush_stays_idle", 32'(busy_o), 32'd0);
    applyStimulus(8'h01);
    tick();
    popCheck("01_msb");
    shiftRest("01_bit");
    strobe();
    checkOutput("01_end_busy", 32'(busy_o), 32'd0);
    tick();
    checkOutput("flush_done_count", 32'(done_count - done_ref), 32'd1);

    // 6. Valid while full is not captured; it is taken once ready returns.
    applyStimulus(8'h96);
    tick();
    popCheck("96_msb");
    applyStimulus(8'h0F);
    data_valid_i = 1'b1;
    data_i       = 8'h55;
    for (int i = 0; i < 7; i++) begin
      strobe();
      popCheck("96_bit");
      checkOutput("full_ready", 32'(data_ready_o), 32'd0);
    end
    strobe();
    popCheck("0f_msb");
    checkOutput("full_ready_back", 32'(data_ready_o), 32'd1);
    tick();
    data_valid_i = 1'b0;
    for (int b = 7; b >= 0; b--) exp_bits.push_back(data_i[b]);
    checkOutput("55_captured", 32'(data_ready_o), 32'd0);
    shiftRest("0f_bit");
    strobe();
    popCheck("55_msb");
    shiftRest("55_bit");
    strobe();
    checkOutput("55_end_busy", 32'(busy_o), 32'd0);
    checkOutput("queue_drained", 32'(exp_bits.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
